mult_bus_master: RTL and testbench

Bus-initiator sequencer that drives the J1-style peripheral bus (cs/addr/rd/wr/d_in/d_out) from the master side. On a start request it performs one full multiply transaction against the multiplier peripheral:
- write operand A
- write operand B
- pulse init
- poll done
- read pp high and pp low

It then returns a 32-bit product to a local client. It lets hardware, such as an energy-accumulation datapath, use the multiplier without going through the CPU.

---
 rtl/mult_bus_master.sv | 209 ++++++++++++++++++++
 tb/tb_mult_bus_master.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_bus_master.sv
// Bus initiator that runs one multiply on the peripheral multiplier per start request:
// write A, write B, pulse init, poll done, read the product halves, report to the client.
module mult_bus_master #(
    parameter logic [3:0] ADDR_A    = 4'h0,
    parameter logic [3:0] ADDR_B    = 4'h2,
    parameter logic [3:0] ADDR_INIT = 4'h4,
    parameter logic [3:0] ADDR_DONE = 4'h6,
    parameter logic [3:0] ADDR_PPH  = 4'h8,
    parameter logic [3:0] ADDR_PPL  = 4'hA,
    parameter int         INIT_WAIT = 2,
    parameter int         POLL_MAX  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic        busy,
    output logic [31:0] result,
    output logic        result_valid,
    output logic        timeout,
    output logic        cs,
    output logic [3:0]  addr,
    output logic        rd,
    output logic        wr,
    output logic [15:0] bus_dout,
    input  logic [15:0] bus_din
);

    // Bus handshake: one access per cycle, cs=1 with exactly one of rd/wr; read data is
    // taken from bus_din on the rising edge that closes the rd cycle.
    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_A,
        S_WR_B,
        S_WR_INIT,
        S_WAIT,
        S_POLL,
        S_GAP,
        S_RD_HI,
        S_RD_LO,
        S_DONE,
        S_TMO
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [15:0] op_b_q;
    logic [15:0] pp_hi;
    logic [7:0]  poll_cnt;
    logic [3:0]  wait_cnt;
    logic        wait_last;
    logic        poll_last;

    logic        cs_nxt;
    logic        rd_nxt;
    logic        wr_nxt;
    logic [3:0]  addr_nxt;
    logic [15:0] dout_nxt;
    logic        busy_nxt;
    logic        valid_nxt;
    logic        timeout_nxt;

    assign wait_last = (int'(wait_cnt) + 1) >= INIT_WAIT;
    assign poll_last = (int'(poll_cnt) + 1) >= POLL_MAX;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (start) next_state = S_WR_A;
            S_WR_A:    next_state = S_WR_B;
            S_WR_B:    next_state = S_WR_INIT;
            S_WR_INIT: next_state = (INIT_WAIT == 0) ? S_POLL : S_WAIT;
            S_WAIT:    if (wait_last) next_state = S_POLL;
            S_POLL: begin
                // Only bit 0 of the status word is meaningful.
                if (bus_din[0])     next_state = S_RD_HI;
                else if (poll_last) next_state = S_TMO;
                else                next_state = S_GAP;
            end
            S_GAP:     next_state = S_POLL;
            S_RD_HI:   next_state = S_RD_LO;
            S_RD_LO:   next_state = S_DONE;
            S_DONE:    next_state = S_IDLE;
            S_TMO:     next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    // Outputs are decoded from the state being entered so every strobe is a flop output.
    always_comb begin
        cs_nxt      = 1'b0;
        rd_nxt      = 1'b0;
        wr_nxt      = 1'b0;
        addr_nxt    = 4'h0;
        dout_nxt    = bus_dout;
        busy_nxt    = 1'b1;
        valid_nxt   = 1'b0;
        timeout_nxt = 1'b0;
        case (next_state)
            S_WR_A: begin
                cs_nxt   = 1'b1;
                wr_nxt   = 1'b1;
                addr_nxt = ADDR_A;
                dout_nxt = op_a;
            end
            S_WR_B: begin
                cs_nxt   = 1'b1;
                wr_nxt   = 1'b1;
                addr_nxt = ADDR_B;
                dout_nxt = op_b_q;
            end
            S_WR_INIT: begin
                cs_nxt   = 1'b1;
                wr_nxt   = 1'b1;
                addr_nxt = ADDR_INIT;
                dout_nxt = 16'h0001;
            end
            S_POLL: begin
                cs_nxt   = 1'b1;
                rd_nxt   = 1'b1;
                addr_nxt = ADDR_DONE;
            end
            S_RD_HI: begin
                cs_nxt   = 1'b1;
                rd_nxt   = 1'b1;
                addr_nxt = ADDR_PPH;
            end
            S_RD_LO: begin
                cs_nxt   = 1'b1;
                rd_nxt   = 1'b1;
                addr_nxt = ADDR_PPL;
            end
            S_IDLE:  busy_nxt = 1'b0;
            S_DONE: begin
                busy_nxt  = 1'b0;
                valid_nxt = 1'b1;
            end
            S_TMO: begin
                busy_nxt    = 1'b0;
                timeout_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs           <= 1'b0;
            rd           <= 1'b0;
            wr           <= 1'b0;
            addr         <= 4'h0;
            bus_dout     <= 16'h0000;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            cs           <= cs_nxt;
            rd           <= rd_nxt;
            wr           <= wr_nxt;
            addr         <= addr_nxt;
            bus_dout     <= dout_nxt;
            busy         <= busy_nxt;
            result_valid <= valid_nxt;
            timeout      <= timeout_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_b_q   <= 16'h0000;
            pp_hi    <= 16'h0000;
            result   <= 32'h0000_0000;
            poll_cnt <= 8'h00;
            wait_cnt <= 4'h0;
        end else begin
            // op_a goes straight onto the bus at the accepting edge; op_b waits a cycle.
            if (state == S_IDLE && start) begin
                op_b_q <= op_b;
            end
            if (state == S_WAIT) begin
                wait_cnt <= wait_cnt + 4'h1;
            end else begin
                wait_cnt <= 4'h0;
            end
            if (next_state == S_WR_A) begin
                poll_cnt <= 8'h00;
            end else if (state == S_POLL && !bus_din[0] && poll_cnt != 8'hFF) begin
                poll_cnt <= poll_cnt + 8'h01;
            end
            if (state == S_RD_HI) begin
                pp_hi <= bus_din;
            end
            if (state == S_RD_LO) begin
                result <= {pp_hi, bus_din};
            end
        end
    end

endmodule

// File: tb/tb_mult_bus_master.sv
// Bench for mult_bus_master: a behavioural multiplier peripheral on the bus and a
// per-cycle expected bus trace built from the transaction rules.
module tb_mult_bus_master;

  localparam int IW = 2;
  localparam int PM = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] op_a = 16'h0;
  logic [15:0] op_b = 16'h0;
  logic [15:0] bus_din = 16'h0;
  logic        busy, result_valid, timeout, cs, rd, wr;
  logic [31:0] result;
  logic [3:0]  addr;
  logic [15:0] bus_dout;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_result = 32'h0;
  logic [15:0] exp_dout = 16'h0;

  mult_bus_master #(.INIT_WAIT(IW), .POLL_MAX(PM)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .result(result), .result_valid(result_valid), .timeout(timeout),
    .cs(cs), .addr(addr), .rd(rd), .wr(wr), .bus_dout(bus_dout), .bus_din(bus_din)
  );

  always #5 clk = ~clk;

  // Peripheral model: acts mid-cycle; done rises done_delay cycles after init,
  // a stale done from the last op stays visible for one cycle after init.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] p_a = 16'h0;
  logic [15:0] p_b = 16'h0;
  logic [31:0] p_prod = 32'h0;
  int p_init_at = -100;
  int done_delay = 4;
  bit stale_done = 1'b1;

  always @(negedge clk) begin : peripheral
    int diff;
    logic done_bit;
    diff = cyc - p_init_at;
    done_bit = (done_delay >= 0 && diff >= done_delay) || (stale_done && diff <= 1);
    bus_din = 16'($urandom);
    if (cs && wr) begin
      case (addr)
        4'h0: p_a = bus_dout;
        4'h2: p_b = bus_dout;
        4'h4: begin
          p_init_at = cyc;
          p_prod = 32'(p_a) * 32'(p_b);
        end
        default: ;
      endcase
    end
    if (cs && rd) begin
      case (addr)
        4'h6: bus_din = {15'($urandom), done_bit};
        4'h8: bus_din = p_prod[31:16];
        4'hA: bus_din = p_prod[15:0];
        default: ;
      endcase
    end
  end

  function automatic logic [25:0] mk(input logic c, input logic r, input logic w,
                                     input logic [3:0] ad, input logic [15:0] d,
                                     input logic b, input logic v, input logic t);
    return {c, r, w, ad, d, b, v, t};
  endfunction

  task automatic check_idle_entry(input string tag);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || cs !== 1'b0 || result !== exp_result) begin
      n_fail++;
      $display("FAIL %s idle_entry: got busy=%b cs=%b result=%h, expected busy=0 cs=0 result=%h",
               tag, busy, cs, result, exp_result);
    end
  endtask

  // One full transaction; delay<0 means the peripheral never reports done.
  task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input int delay,
                         input bit hold, input bit poke, input string tag);
    logic [25:0] exp_q[$];
    logic [25:0] obs;
    logic [25:0] exp_w;
    logic [15:0] last_d;
    int p;
    bit seen;
    done_delay = delay;
    check_idle_entry(tag);
    start = 1'b1;
    op_a = a;
    op_b = b;
    exp_q = {};
    exp_q.push_back(mk(1, 0, 1, 4'h0, a, 1, 0, 0));
    exp_q.push_back(mk(1, 0, 1, 4'h2, b, 1, 0, 0));
    exp_q.push_back(mk(1, 0, 1, 4'h4, 16'h0001, 1, 0, 0));
    last_d = 16'h0001;
    for (int i = 0; i < IW; i++) exp_q.push_back(mk(0, 0, 0, 4'h0, last_d, 1, 0, 0));
    seen = 1'b0;
    for (int k = 0; k < PM; k++) begin
      p = exp_q.size() + 1;
      exp_q.push_back(mk(1, 1, 0, 4'h6, 16'h0, 1, 0, 0));
      if (delay >= 0 && p - 3 >= delay) begin
        seen = 1'b1;
        break;
      end
      if (k < PM - 1) exp_q.push_back(mk(0, 0, 0, 4'h0, last_d, 1, 0, 0));
    end
    if (seen) begin
      exp_q.push_back(mk(1, 1, 0, 4'h8, 16'h0, 1, 0, 0));
      exp_q.push_back(mk(1, 1, 0, 4'hA, 16'h0, 1, 0, 0));
      exp_q.push_back(mk(0, 0, 0, 4'h0, last_d, 0, 1, 0));
      exp_result = 32'(a) * 32'(b);
    end else begin
      exp_q.push_back(mk(0, 0, 0, 4'h0, last_d, 0, 0, 1));
    end
    exp_dout = last_d;
    for (int r = 1; r <= exp_q.size(); r++) begin
      @(negedge clk);
      exp_w = exp_q[r-1];
      obs = {cs, rd, wr, addr, (cs && rd) ? 16'h0 : bus_dout, busy, result_valid, timeout};
      n_checks++;
      if (obs !== exp_w) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got cs,rd,wr,addr,dout,busy,rv,tmo=%b,%b,%b,%h,%h,%b,%b,%b expected %b,%b,%b,%h,%h,%b,%b,%b",
                 tag, r, obs[25], obs[24], obs[23], obs[22:19], obs[18:3], obs[2], obs[1], obs[0],
                 exp_w[25], exp_w[24], exp_w[23], exp_w[22:19], exp_w[18:3], exp_w[2], exp_w[1], exp_w[0]);
      end
      if (r == 1 && !hold) start = 1'b0;
      if (poke && r == IW + 4) start = 1'b1;
      else if (poke && r == IW + 5) start = 1'b0;
    end
    n_checks++;
    if (result !== exp_result) begin
      n_fail++;
      $display("FAIL %s result: got %h expected %h", tag, result, exp_result);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    n_checks++;
    if ({busy, result, result_valid, timeout, cs, rd, wr, addr, bus_dout} !== 58'h0) begin
      n_fail++;
      $display("FAIL reset_values: got busy=%b result=%h rv=%b tmo=%b cs=%b rd=%b wr=%b addr=%h dout=%h expected all zero",
               busy, result, result_valid, timeout, cs, rd, wr, addr, bus_dout);
    end
    exp_result = 32'h0;
    exp_dout = 16'h0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    run_txn(16'd3, 16'd5, 4, 1'b0, 1'b0, "basic_3x5");
    n_checks++;
    if (result !== 32'h0000_000F) begin
      n_fail++;
      $display("FAIL basic_const: got %h expected 0000000f", result);
    end
  endtask

  task automatic test_max_operands();
    run_txn(16'hFFFF, 16'hFFFF, 4, 1'b0, 1'b0, "max_ffff");
    n_checks++;
    if (result !== 32'hFFFE_0001) begin
      n_fail++;
      $display("FAIL max_const: got %h expected fffe0001", result);
    end
  endtask

  task automatic test_timeout();
    run_txn(16'h1234, 16'h0042, -1, 1'b0, 1'b0, "timeout");
  endtask

  task automatic test_stale_done();
    stale_done = 1'b1;
    run_txn(16'($urandom), 16'($urandom), 3, 1'b0, 1'b0, "stale_done");
  endtask

  task automatic test_start_during_poll();
    run_txn(16'h00AB, 16'h0CD0, 6, 1'b0, 1'b1, "start_in_poll");
    run_txn(16'h0101, 16'h0202, 4, 1'b0, 1'b0, "after_poll_poke");
  endtask

  task automatic test_back_to_back();
    run_txn(16'h1111, 16'h0003, 4, 1'b1, 1'b0, "b2b_0");
    run_txn(16'h7FFF, 16'h0002, 3, 1'b1, 1'b0, "b2b_1");
    run_txn(16'h8001, 16'h8001, 5, 1'b0, 1'b0, "b2b_2");
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      run_txn(16'($urandom), 16'($urandom), int'($urandom_range(2, 10)), 1'b0, 1'b0, "random");
    end
  endtask

  task automatic test_reset_mid();
    done_delay = 4;
    check_idle_entry("reset_mid");
    start = 1'b1;
    op_a = 16'h0BAD;
    op_b = 16'h0F00;
    for (int r = 1; r <= 9; r++) begin
      @(negedge clk);
      if (r == 1) start = 1'b0;
    end
    n_checks++;
    if ({cs, rd, wr, addr} !== {1'b1, 1'b1, 1'b0, 4'h8}) begin
      n_fail++;
      $display("FAIL reset_mid_rd_hi: got cs=%b rd=%b wr=%b addr=%h expected 1,1,0,8", cs, rd, wr, addr);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({cs, rd, busy, result} !== 35'h0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got cs=%b rd=%b busy=%b result=%h expected 0,0,0,0", cs, rd, busy, result);
    end
    exp_result = 32'h0;
    exp_dout = 16'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    run_txn(16'h0020, 16'h0030, 4, 1'b0, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max_operands();
    test_timeout();
    test_stale_done();
    test_start_during_poll();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
